// File: rtl/bus_loader_if.sv
// bus_loader_if: groups the command, LOAD/DUMP stream and memory bus
// signals of bus_loader.
//   cmd_*              command request (valid/ready; dump, base, len)
//   in_*               LOAD byte stream into the loader (valid/ready)
//   out_*              DUMP byte stream out of the loader (valid/ready)
//   address/to_memory/write/from_memory   memory bus driven by the loader
//   cpu_hold           keeps the CPU in reset and grants the bus
//   done               one-cycle completion pulse
// Modport slave is the bus_loader side, modport master the controller side.
interface bus_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dump;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] to_memory;
  logic [DATA_WIDTH-1:0] from_memory;
  logic                  write;
  logic                  cpu_hold;
  logic                  done;

  modport slave (
    input  cmd_valid, cmd_dump, cmd_base, cmd_len,
    input  in_data, in_valid, out_ready, from_memory,
    output cmd_ready, in_ready, out_data, out_valid,
    output address, to_memory, write, cpu_hold, done
  );

  modport master (
    output cmd_valid, cmd_dump, cmd_base, cmd_len,
    output in_data, in_valid, out_ready, from_memory,
    input  cmd_ready, in_ready, out_data, out_valid,
    input  address, to_memory, write, cpu_hold, done
  );
endinterface

// File: rtl/bus_loader.sv
// bus_loader: bus initiator used while the CPU is held in reset.
//   LOAD: writes a valid/ready byte stream to consecutive memory addresses.
//   DUMP: reads consecutive addresses and emits them as a valid/ready stream.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    bus_loader_if.slave (command, in/out streams, memory bus,
//          cpu_hold, done); every output is registered.
module bus_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  bus_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_WRITE,
    RD_ADDR,
    RD_WAIT,
    RD_OUT,
    FINISH
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] ptr, ptr_d;
  logic [ADDR_WIDTH:0]   remaining, remaining_d;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] to_memory_d, out_data_d;
  logic cmd_ready_d, in_ready_d, out_valid_d, write_d, cpu_hold_d, done_d;

  logic accept, in_fire, out_fire, last;

  assign accept   = bus.cmd_valid & bus.cmd_ready;
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign last     = (remaining == (ADDR_WIDTH+1)'(1));

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      remaining     <= '0;
      bus.address   <= '0;
      bus.to_memory <= '0;
      bus.out_data  <= '0;
      bus.write     <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.cpu_hold  <= 1'b0;
      bus.done      <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else begin
      state         <= next_state;
      ptr           <= ptr_d;
      remaining     <= remaining_d;
      bus.address   <= address_d;
      bus.to_memory <= to_memory_d;
      bus.out_data  <= out_data_d;
      bus.write     <= write_d;
      bus.in_ready  <= in_ready_d;
      bus.out_valid <= out_valid_d;
      bus.cpu_hold  <= cpu_hold_d;
      bus.done      <= done_d;
      bus.cmd_ready <= cmd_ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = bus.cmd_dump ? RD_ADDR : LD_WAIT;
      LD_WAIT:  if (in_fire) next_state = LD_WRITE;
      LD_WRITE: next_state = last ? FINISH : LD_WAIT;
      RD_ADDR:  next_state = RD_WAIT;
      RD_WAIT:  next_state = RD_OUT;
      RD_OUT:   if (out_fire) next_state = last ? FINISH : RD_ADDR;
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output logic. Flag outputs are decoded from next_state so that, once
  // registered, they line up exactly with the state they belong to.
  always_comb begin
    ptr_d       = ptr;
    remaining_d = remaining;
    to_memory_d = bus.to_memory;
    out_data_d  = bus.out_data;
    address_d   = bus.address;

    case (state)
      IDLE: begin
        if (accept) begin
          ptr_d       = bus.cmd_base;
          remaining_d = (bus.cmd_len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                            : {1'b0, bus.cmd_len};
        end
      end
      LD_WAIT: begin
        if (in_fire) to_memory_d = bus.in_data;
      end
      LD_WRITE: begin
        ptr_d       = ptr + ADDR_WIDTH'(1);
        remaining_d = remaining - (ADDR_WIDTH+1)'(1);
      end
      // Memory data for the address issued in RD_ADDR is valid here.
      RD_WAIT: out_data_d = bus.from_memory;
      RD_OUT: begin
        if (out_fire) begin
          ptr_d       = ptr + ADDR_WIDTH'(1);
          remaining_d = remaining - (ADDR_WIDTH+1)'(1);
        end
      end
      default: ;
    endcase

    // Address is presented while writing, and on entry to each read.
    if (next_state == LD_WRITE || next_state == RD_ADDR) address_d = ptr_d;

    cmd_ready_d = (next_state == IDLE);
    in_ready_d  = (next_state == LD_WAIT);
    write_d     = (next_state == LD_WRITE);
    out_valid_d = (next_state == RD_OUT);
    done_d      = (next_state == FINISH);
    cpu_hold_d  = (next_state != IDLE);
  end

endmodule

// File: tb/tb_bus_loader.sv
// tb_bus_loader: directed test of bus_loader with a registered memory model,
// a LOAD stream source and a DUMP stream sink.
module tb_bus_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bif ();

  bus_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Registered memory: read data valid one cycle after the address.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bif.write) mem[bif.address] <= bif.to_memory;
    bif.from_memory <= mem[bif.address];
  end

  // LOAD stream source: advances on each handshake.
  logic [7:0] src_mem [1024];
  int src_idx = 0;
  always @(posedge clk) if (bif.in_valid && bif.in_ready) src_idx <= src_idx + 1;
  always_comb bif.in_data = src_mem[src_idx[9:0]];

  // Logs of memory writes, stream outputs and done pulses.
  int cyc = 0;
  logic [7:0] wr_a[$], wr_d[$], out_q[$];
  int wr_c[$], out_c[$];
  int done_cnt = 0;
  int viol = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bif.write) begin
      wr_a.push_back(bif.address);
      wr_d.push_back(bif.to_memory);
      wr_c.push_back(cyc);
    end
    if (bif.out_valid && bif.out_ready) begin
      out_q.push_back(bif.out_data);
      out_c.push_back(cyc);
    end
    if (bif.done) done_cnt <= done_cnt + 1;
  end
  always @(negedge clk) if (bif.in_ready && bif.out_valid) viol++;

  // Called at a negedge with cmd_ready=1; returns at the negedge after accept.
  task automatic issue(input string tag, input logic dump, input logic [7:0] base,
                       input logic [7:0] len);
    bif.cmd_valid = 1'b1;
    bif.cmd_dump  = dump;
    bif.cmd_base  = base;
    bif.cmd_len   = len;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    check({tag, "_accept"}, bif.cmd_ready, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int gap = 0;
    for (int n = 0; n < 2000; n++) begin
      if (bif.done) break;
      if (!bif.cpu_hold) gap++;
      @(negedge clk);
    end
    check({tag, "_done"}, bif.done, 1'b1);
    check({tag, "_hold_gap"}, gap, 0);
    check({tag, "_hold_at_done"}, bif.cpu_hold, 1'b1);
    @(negedge clk);
    check({tag, "_hold_after"}, bif.cpu_hold, 1'b0);
    check({tag, "_done_pulse"}, bif.done, 1'b0);
    check({tag, "_idle_ready"}, bif.cmd_ready, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_write"}, bif.write, 1'b0);
    check({tag, "_in_ready"}, bif.in_ready, 1'b0);
    check({tag, "_out_valid"}, bif.out_valid, 1'b0);
    check({tag, "_cpu_hold"}, bif.cpu_hold, 1'b0);
    check({tag, "_cmd_ready"}, bif.cmd_ready, 1'b1);
    check({tag, "_done"}, bif.done, 1'b0);
    check({tag, "_address"}, bif.address, 8'h00);
  endtask

  initial begin
    int b, d0, s0, n0, errs;
    logic [7:0] exp_a [4];
    logic [7:0] hold_addr;

    reset         = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.cmd_dump  = 1'b0;
    bif.cmd_base  = '0;
    bif.cmd_len   = '0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst");
    check("rst_to_memory", bif.to_memory, 8'h00);
    check("rst_out_data", bif.out_data, 8'h00);

    // LOAD 0x10, 3 bytes, in_valid held high.
    src_mem[src_idx]     = 8'hA1;
    src_mem[src_idx + 1] = 8'hB2;
    src_mem[src_idx + 2] = 8'hC3;
    bif.in_valid = 1'b1;
    b  = wr_a.size();
    d0 = done_cnt;
    issue("ld1", 1'b0, 8'h10, 8'd3);
    wait_done("ld1");
    bif.in_valid = 1'b0;
    check("ld1_nwr", wr_a.size() - b, 3);
    check("ld1_a0", {wr_a[b], wr_d[b]}, 16'h10A1);
    check("ld1_a1", {wr_a[b+1], wr_d[b+1]}, 16'h11B2);
    check("ld1_a2", {wr_a[b+2], wr_d[b+2]}, 16'h12C3);
    check("ld1_rate", wr_c[b+2] - wr_c[b], 4);
    check("ld1_ndone", done_cnt - d0, 1);

    // DUMP 0x10, 3 bytes, out_ready high.
    b = out_q.size();
    issue("rd1", 1'b1, 8'h10, 8'd3);
    wait_done("rd1");
    check("rd1_n", out_q.size() - b, 3);
    check("rd1_d0", out_q[b], 8'hA1);
    check("rd1_d1", out_q[b+1], 8'hB2);
    check("rd1_d2", out_q[b+2], 8'hC3);
    check("rd1_rate01", out_c[b+1] - out_c[b], 3);
    check("rd1_rate12", out_c[b+2] - out_c[b+1], 3);

    // DUMP with a 5-cycle out_ready stall on byte 2.
    b = out_q.size();
    issue("rd2", 1'b1, 8'h10, 8'd3);
    for (int n = 0; n < 20 && out_q.size() < b + 1; n++) @(negedge clk);
    bif.out_ready = 1'b0;
    for (int n = 0; n < 20 && !bif.out_valid; n++) @(negedge clk);
    check("rd2_valid", bif.out_valid, 1'b1);
    hold_addr = bif.address;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (!bif.out_valid || bif.out_data !== 8'hB2 || bif.address !== hold_addr) errs++;
      @(negedge clk);
    end
    check("rd2_stall_addr", hold_addr, 8'h11);
    check("rd2_stall_errs", errs, 0);
    check("rd2_stalled_n", out_q.size() - b, 1);
    bif.out_ready = 1'b1;
    wait_done("rd2");
    check("rd2_n", out_q.size() - b, 3);
    check("rd2_d1", out_q[b+1], 8'hB2);
    check("rd2_d2", out_q[b+2], 8'hC3);

    // cmd_valid and in_valid during a DUMP are ignored.
    b  = out_q.size();
    n0 = wr_a.size();
    src_mem[src_idx] = 8'h5E;
    bif.in_valid = 1'b1;
    s0 = src_idx;
    issue("rd3", 1'b1, 8'h10, 8'd2);
    @(negedge clk);
    bif.cmd_valid = 1'b1;
    bif.cmd_dump  = 1'b0;
    bif.cmd_base  = 8'h99;
    bif.cmd_len   = 8'd1;
    check("rd3_busy_ready", bif.cmd_ready, 1'b0);
    check("rd3_in_ready", bif.in_ready, 1'b0);
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    wait_done("rd3");
    repeat (2) @(negedge clk);
    check("rd3_no_restart", bif.cpu_hold, 1'b0);
    check("rd3_no_write", wr_a.size() - n0, 0);
    check("rd3_no_consume", src_idx - s0, 0);
    check("rd3_out", {out_q[b], out_q[b+1]}, 16'hA1B2);
    bif.in_valid = 1'b0;

    // Reset during LD_WRITE.
    for (int i = 0; i < 4; i++) src_mem[src_idx + i] = 8'h60 + 8'(i);
    bif.in_valid = 1'b1;
    issue("rst1", 1'b0, 8'h40, 8'd4);
    for (int n = 0; n < 20 && !bif.write; n++) @(negedge clk);
    check("rst1_in_write", bif.write, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n0 = wr_a.size();
    check_reset_state("rst1");
    repeat (6) @(negedge clk);
    check("rst1_no_write", wr_a.size() - n0, 0);
    check("rst1_idle_in_ready", bif.in_ready, 1'b0);

    // Normal command after the aborted one.
    src_mem[src_idx] = 8'h77;
    b = wr_a.size();
    issue("ld2", 1'b0, 8'h50, 8'd1);
    wait_done("ld2");
    bif.in_valid = 1'b0;
    check("ld2_nwr", wr_a.size() - b, 1);
    check("ld2_w", {wr_a[b], wr_d[b]}, 16'h5077);

    // Reset during RD_OUT.
    bif.out_ready = 1'b0;
    b = out_q.size();
    issue("rst2", 1'b1, 8'h10, 8'd3);
    for (int n = 0; n < 20 && !bif.out_valid; n++) @(negedge clk);
    check("rst2_in_out", bif.out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst2");
    bif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_no_out", out_q.size() - b, 0);

    // LOAD with address wrap.
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    for (int i = 0; i < 4; i++) src_mem[src_idx + i] = 8'h11 * 8'(i + 1);
    bif.in_valid = 1'b1;
    b = wr_a.size();
    issue("wrap", 1'b0, 8'hFE, 8'd4);
    wait_done("wrap");
    check("wrap_nwr", wr_a.size() - b, 4);
    errs = 0;
    for (int i = 0; i < 4; i++)
      if (wr_a[b+i] !== exp_a[i] || wr_d[b+i] !== 8'h11 * 8'(i + 1)) errs++;
    check("wrap_addrs", errs, 0);

    // len=0 LOAD: 256 writes starting at 0x80.
    for (int i = 0; i < 256; i++) src_mem[(src_idx + i) % 1024] = 8'(i) ^ 8'h5A;
    b  = wr_a.size();
    d0 = done_cnt;
    issue("len0", 1'b0, 8'h80, 8'd0);
    wait_done("len0");
    bif.in_valid = 1'b0;
    check("len0_nwr", wr_a.size() - b, 256);
    check("len0_ndone", done_cnt - d0, 1);
    errs = 0;
    for (int i = 0; i < 256 && b + i < wr_a.size(); i++)
      if (wr_a[b+i] !== 8'(8'h80 + 8'(i)) || wr_d[b+i] !== (8'(i) ^ 8'h5A)) errs++;
    check("len0_seq", errs, 0);
    check("len0_last", wr_a[wr_a.size() - 1], 8'h7F);

    check("no_ready_valid_overlap", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
